// File: rtl/move_collector.sv
// Move collector: gathers a batch of (score, position) beats into SLOTS parallel
// slots for the downstream arbiter. Define COLLECT_SKIP_ZERO_EN to drop zero-score beats.
module move_collector #(
  parameter int SLOTS = 64,
  parameter int W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_score,
  input  logic [W-1:0]       in_pos,
  input  logic               in_last,
  output logic               bank_valid,
  input  logic               bank_ack,
  output logic [SLOTS*W-1:0] score_bus,
  output logic [SLOTS*W-1:0] pos_bus,
  output logic [6:0]         count,
  output logic [0:0]         dbg_state_o
);

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
  // a bank is consumed on a rising edge where bank_valid && bank_ack.
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [6:0] LAST_IDX = 7'(SLOTS - 1);

  logic [0:0]         state_q, state_d;
  logic               armed_q;
  logic [6:0]         count_q, count_d;
  logic [SLOTS*W-1:0] score_q, score_d;
  logic [SLOTS*W-1:0] pos_q, pos_d;
  logic               accept;
  logic               store;

  assign in_ready    = armed_q && (state_q == FILL);
  assign bank_valid  = (state_q == HOLD);
  assign accept      = in_valid && in_ready;
  assign score_bus   = score_q;
  assign pos_bus     = pos_q;
  assign count       = count_q;
  assign dbg_state_o = state_q;

`ifdef COLLECT_SKIP_ZERO_EN
  // Zero-score beats still handshake (and may end the batch) but take no slot.
  assign store = (in_score != '0);
`else
  assign store = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    score_d = score_q;
    pos_d   = pos_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (store) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (count_q == 7'(i)) begin
                score_d[i*W +: W] = in_score;
                pos_d[i*W +: W]   = in_pos;
              end
            end
            count_d = count_q + 7'd1;
          end
          if (in_last || (store && (count_q == LAST_IDX))) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bank_ack) begin
          state_d = FILL;
          count_d = '0;
          score_d = '0;
          pos_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // armed_q keeps in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      armed_q <= 1'b0;
      count_q <= '0;
      score_q <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      count_q <= count_d;
      score_q <= score_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: directed batches plus random traffic
// compared against a queue-based reference model.
module tb_move_collector;
  localparam int SLOTS = 64;
  localparam int W     = 6;
  localparam int BW    = SLOTS * W;
`ifdef COLLECT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk, rst;
  logic          in_valid, in_ready, in_last, bank_valid, bank_ack;
  logic [W-1:0]  in_score, in_pos;
  logic [BW-1:0] score_bus, pos_bus;
  logic [6:0]    count;
  logic [0:0]    dbg_state;

  move_collector #(.SLOTS(SLOTS), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_pos(in_pos), .in_last(in_last),
    .bank_valid(bank_valid), .bank_ack(bank_ack), .score_bus(score_bus),
    .pos_bus(pos_bus), .count(count), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: stored beats in order, plus hold / armed flags
  logic [W-1:0] sq[$];
  logic [W-1:0] pq[$];
  bit hold_m  = 1'b0;
  bit armed_m = 1'b0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_q(input bit use_pos);
    logic [BW-1:0] r = '0;
    for (int i = 0; i < sq.size(); i++) r[i*W +: W] = use_pos ? pq[i] : sq[i];
    return r;
  endfunction

  task automatic check_all(input string where);
    check({where, ".in_ready"},   BW'(in_ready),   BW'(armed_m && !hold_m));
    check({where, ".bank_valid"}, BW'(bank_valid), BW'(hold_m));
    check({where, ".count"},      BW'(count),      BW'(sq.size()));
    check({where, ".score_bus"},  score_bus,       pack_q(1'b0));
    check({where, ".pos_bus"},    pos_bus,         pack_q(1'b1));
  endtask

  // driver: apply one cycle of inputs, advance the model at the edge, then compare
  task automatic step(input logic v, input logic [W-1:0] s, input logic [W-1:0] p,
                      input logic l, input logic a, input string where);
    in_valid = v; in_score = s; in_pos = p; in_last = l; bank_ack = a;
    @(posedge clk);
    if (v && armed_m && !hold_m) begin
      if (!(SKIP && s == '0)) begin
        sq.push_back(s);
        pq.push_back(p);
      end
      if (l || sq.size() == SLOTS) hold_m = 1'b1;
    end else if (hold_m && a) begin
      sq.delete();
      pq.delete();
      hold_m = 1'b0;
    end
    armed_m = 1'b1;
    #1;
    check_all(where);
  endtask

  task automatic idle(input string where);
    step(1'b0, '0, '0, 1'b0, 1'b0, where);
  endtask

  task automatic ack(input string where);
    step(1'b0, '0, '0, 1'b0, 1'b1, where);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_score = '0; in_pos = '0; in_last = 1'b0; bank_ack = 1'b0;
    #2;
    check_all("reset_pre_clk");
    @(posedge clk); #1;
    check_all("reset_held");
    #4 rst = 1'b0;
    check_all("reset_released");
    idle("first_edge");

    // single beat with last
    step(1'b1, 6'b100000, 6'b100001, 1'b1, 1'b0, "single_last");
    idle("single_hold");
    ack("single_ack");

    // 64 back-to-back beats, no last
    for (int i = 0; i < SLOTS; i++) step(1'b1, W'(i), W'(i), 1'b0, 1'b0, "fill64");
    if (SKIP) step(1'b1, 6'd1, 6'd1, 1'b0, 1'b0, "fill64_extra");
    // held beat while in HOLD, then ack with it still pending
    for (int i = 0; i < 5; i++) step(1'b1, 6'd9, 6'd3, 1'b0, 1'b0, "hold_stall");
    step(1'b1, 6'd9, 6'd3, 1'b0, 1'b1, "hold_ack");
    step(1'b1, 6'd9, 6'd3, 1'b0, 1'b0, "held_beat_lands");
    step(1'b1, 6'd2, 6'd2, 1'b1, 1'b0, "close_batch");
    ack("ack2");

    // zero-score sequence
    step(1'b1, 6'd0, 6'd10, 1'b0, 1'b0, "zero_a");
    step(1'b1, 6'd5, 6'd11, 1'b0, 1'b0, "zero_b");
    step(1'b1, 6'd0, 6'd12, 1'b0, 1'b0, "zero_c");
    step(1'b1, 6'd7, 6'd13, 1'b1, 1'b0, "zero_d");
    ack("zero_ack");
    step(1'b1, 6'd0, 6'd14, 1'b1, 1'b0, "zero_only_last");
    ack("zero_only_ack");

    // asynchronous reset after 10 accepts
    for (int i = 0; i < 10; i++) step(1'b1, W'(i + 20), W'(i + 30), 1'b0, 1'b0, "pre_reset");
    #2 rst = 1'b1;
    sq.delete(); pq.delete(); hold_m = 1'b0; armed_m = 1'b0;
    #1 check_all("async_reset");
    #1 rst = 1'b0;
    step(1'b1, 6'd33, 6'd44, 1'b1, 1'b0, "post_reset_first");
    step(1'b1, 6'd33, 6'd44, 1'b1, 1'b0, "post_reset_beat");
    ack("post_reset_ack");

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [W-1:0] s;
      s = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      step(logic'($urandom_range(0, 9) < 7), s, W'($urandom),
           logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 3) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 The module SHALL expose parameter SLOTS, default 64, number of candidate slots presented to the downstream arbiter.
REQ-002 The module SHALL expose parameter W, default 6, bit width of each score and each position.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream candidate beat valid.
REQ-006 in_ready  output  1  collector can accept a beat.
REQ-007 in_score  input  W  candidate move score.
REQ-008 in_pos  input  W  candidate board position.
REQ-009 in_last  input  1  final candidate of the batch; qualified by in_valid.
REQ-010 bank_valid  output  1  score_bus/pos_bus hold a complete batch for the arbiter.
REQ-011 bank_ack  input  1  arbiter has consumed the batch.
REQ-012 score_bus  output  SLOTS*W  slot i occupies bits [W*i+W-1:W*i]; slot 0 drives arbiter in1, slot 63 drives in64.
REQ-013 pos_bus  output  SLOTS*W  same packing; slot 0 drives inpos_1.
REQ-014 count  output  7  number of slots filled in the current batch, 0..SLOTS.

Function
REQ-015 The block SHALL have two states: FILL (in_ready=1, bank_valid=0) and HOLD (in_ready=0, bank_valid=1).
REQ-016 A beat SHALL be accepted exactly when in_valid and in_ready are both high at a rising edge.
REQ-017 In FILL, an accepted beat SHALL write in_score/in_pos into slot[count] and increment count by 1 in the same edge.
REQ-018 FILL→HOLD SHALL occur on the edge that accepts a beat with in_last=1, or the edge that accepts the beat filling slot SLOTS-1, whichever comes first.
REQ-019 bank_valid SHALL assert in the cycle immediately after the terminating accept (latency 1).
REQ-020 Unfilled slots SHALL read as all-zero on score_bus and pos_bus throughout HOLD.
REQ-021 In HOLD, score_bus, pos_bus and count SHALL remain stable until bank_ack is sampled high.
REQ-022 HOLD→FILL SHALL occur on the edge sampling bank_ack=1, clearing every slot to zero and count to 0 on that edge; in_ready rises the following cycle.
REQ-023 bank_ack in FILL SHALL be ignored.
REQ-024 in_valid in HOLD SHALL be ignored; the beat is not accepted and upstream holds it.
REQ-025 in_last on the beat that also fills slot SLOTS-1 SHALL produce a single FILL→HOLD transition, no extra effect.
REQ-026 count SHALL never exceed SLOTS and SHALL never wrap.

Reset
REQ-027 While rst=1, all slots SHALL be zero, count=0, state=FILL, bank_valid=0, in_ready=0, independent of clk.
REQ-028 in_ready SHALL rise on the first rising clk edge after rst deasserts.
REQ-029 Reset asserted mid-FILL or mid-HOLD SHALL discard the partial or held batch with no bank_valid pulse.

Configuration
REQ-030 Macro COLLECT_SKIP_ZERO_EN SHALL control zero-score filtering.
REQ-031 With COLLECT_SKIP_ZERO_EN defined, an accepted beat with in_score==0 SHALL complete the handshake but SHALL NOT be stored and SHALL NOT increment count; its in_last still forces FILL→HOLD, including with count=0 (all-zero bank).
REQ-032 Without COLLECT_SKIP_ZERO_EN, zero-score beats SHALL be stored like any other beat.

Verification
REQ-033 Reset, then one beat score=6'b100000 pos=6'b100001 last=1 -> next cycle bank_valid=1, count=1, slot0=(100000,100001), slots 1..63 zero.
REQ-034 64 back-to-back beats, score=i, pos=i (i=0..63), last never set -> bank_valid one cycle after the 64th accept, count=64, slot i=(i,i); in_ready low during HOLD.
REQ-035 HOLD with in_valid held high for 5 cycles, then bank_ack pulse -> no accepts during HOLD, buses stable; after ack all slots zero, count=0, in_ready=1 next cycle, held beat lands in slot0.
REQ-036 rst asserted asynchronously after 10 accepts -> outputs clear immediately without a clk edge; no bank_valid; next batch starts at slot0.
REQ-037 COLLECT_SKIP_ZERO_EN defined, beats scores 0,5,0,7(last) -> count=2, slot0=5, slot1=7; undefined -> count=4, slot0=0, slot1=5, slot2=0, slot3=7.
